pipe_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter for the ALU datapath. Supports logical left, logical right, arithmetic right and rotate right.
- One log2 stage per shift-amount bit, with a register after every stage. This takes the shift network out of the single-cycle critical path.
- Valid/ready handshake with full-pipeline backpressure. A sideband tag travels with each operation so the issuing unit can match results.

---
 rtl/pipe_shifter.sv | 162 ++++++++++++++++
 tb/tb_pipe_shifter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one register stage per shift-amount bit,
// valid/ready handshake with full-pipeline stall. Define SHIFTER_FLAGS_EN for out_zero/out_carry.
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAGW  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Sign is the original operand MSB, so SRA never re-reads partially shifted data.
    typedef struct packed {
        logic            valid;
        op_e             op;
        logic            sign;
        logic [TAGW-1:0] tag;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic adv;

    // The whole pipe moves together or not at all; bubbles are never collapsed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int DIST = 1 << (SHW - 1 - k);
        localparam logic [WIDTH-1:0] SIGN_FILL = ~({WIDTH{1'b1}} >> DIST);

        stage_t           src;
        logic             en;
        logic [WIDTH-1:0] shifted;
`ifdef SHIFTER_FLAGS_EN
        logic             cin;
        logic             cout;
`endif

        if (k == 0) begin : g_src
            assign src = '{valid: in_valid, op: op_e'(in_op), sign: in_data[WIDTH-1],
                           tag: in_tag, data: in_data};
            assign en  = in_shamt[SHW-1];
`ifdef SHIFTER_FLAGS_EN
            assign cin = 1'b0;
`endif
        end else begin : g_src
            assign src = g_stage[k-1].g_reg.q;
            assign en  = g_stage[k-1].g_reg.amt_q[SHW-1-k];
`ifdef SHIFTER_FLAGS_EN
            assign cin = g_stage[k-1].g_reg.carry_q;
`endif
        end

        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            shifted = src.data;
            if (en) begin
                case (src.op)
                    OP_SLL: shifted = src.data << DIST;
                    OP_SRL: shifted = src.data >> DIST;
                    OP_SRA: shifted = (src.data >> DIST) | (src.sign ? SIGN_FILL : '0);
                    OP_ROR: shifted = (src.data >> DIST) | (src.data << (WIDTH - DIST));
                    default: shifted = src.data;
                endcase
            end
        end

`ifdef SHIFTER_FLAGS_EN
        // The last non-zero stage decides the carry; it always lands on the operand's last bit out.
        always_comb begin
            cout = cin;
            if (en && src.op != OP_ROR) begin
                cout = (src.op == OP_SLL) ? src.data[WIDTH-DIST] : src.data[DIST-1];
            end
        end
`endif

        if (k < SHW - 1) begin : g_reg
            stage_t          q;
            logic [SHW-2-k:0] amt_q;
            logic [SHW-2-k:0] amt_rest;

            if (k == 0) begin : g_amt
                assign amt_rest = in_shamt[SHW-2:0];
            end else begin : g_amt
                assign amt_rest = g_stage[k-1].g_reg.amt_q[SHW-2-k:0];
            end

            // NOTE: state updates use non-blocking assignments so every stage samples its neighbour's pre-edge value.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q     <= '0;
                    amt_q <= '0;
                end else if (adv) begin
                    q     <= '{valid: src.valid, op: src.op, sign: src.sign,
                               tag: src.tag, data: shifted};
                    amt_q <= amt_rest;
                end
            end

`ifdef SHIFTER_FLAGS_EN
            logic carry_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    carry_q <= 1'b0;
                end else if (adv) begin
                    carry_q <= cout;
                end
            end
`endif
        end else begin : g_out
            // NOTE: data registers are reset too, since out_data and out_tag must read zero out of reset.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_tag   <= '0;
                end else if (adv) begin
                    out_valid <= src.valid;
                    out_data  <= shifted;
                    out_tag   <= src.tag;
                end
            end

`ifdef SHIFTER_FLAGS_EN
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_zero  <= 1'b0;
                    out_carry <= 1'b0;
                end else if (adv) begin
                    out_zero  <= (shifted == '0);
                    out_carry <= cout;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: queue-based reference pipeline compared every cycle,
// plus directed latency, ordering, backpressure, reset and flag cases.
module tb_pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_tag;
`ifdef SHIFTER_FLAGS_EN
    logic             out_zero;
    logic             out_carry;
`endif

    always #5 clock = ~clock;

    pipe_shifter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
`ifdef SHIFTER_FLAGS_EN
        ,
        .out_zero (out_zero),
        .out_carry(out_carry)
`endif
    );

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] d;
        logic [TAGW-1:0]  t;
        bit               c;
    } exp_t;

    exp_t             pipe[$];
    logic [WIDTH-1:0] cap_d[$];
    logic [TAGW-1:0]  cap_t[$];
    int               n_vec = 0;
    int               n_err = 0;

    // Places a byte at the top of the word, so the same vectors hold for any WIDTH >= 8.
    function automatic logic [WIDTH-1:0] top(input logic [7:0] b);
        logic [WIDTH-1:0] r;
        r = WIDTH'(b);
        return r << (WIDTH - 8);
    endfunction

    function automatic logic [WIDTH-1:0] ref_res(input logic [1:0] op, input int sh,
                                                 input logic [WIDTH-1:0] d);
        case (op)
            SLL:     return d << sh;
            SRL:     return d >> sh;
            SRA:     return $signed(d) >>> sh;
            default: return (sh == 0) ? d : ((d >> sh) | (d << (WIDTH - sh)));
        endcase
    endfunction

    function automatic bit ref_carry(input logic [1:0] op, input int sh,
                                     input logic [WIDTH-1:0] d);
        if (sh == 0 || op == ROR) return 1'b0;
        if (op == SLL) return d[WIDTH-sh];
        return d[sh-1];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_t b;
        b = '{v: 1'b0, d: '0, t: '0, c: 1'b0};
        pipe.delete();
        for (int i = 0; i < SHW; i++) pipe.push_back(b);
    endtask

    // Compares DUT outputs against the model, then advances the model with the current inputs.
    task automatic observe();
        exp_t head;
        exp_t nw;
        bit   m_adv;
        if (reset) begin
            check("out_valid_in_reset", out_valid, 0);
            model_reset();
            return;
        end
        head  = pipe[SHW-1];
        m_adv = !head.v || out_ready;
        check("out_valid", out_valid, head.v);
        check("in_ready", in_ready, m_adv);
        if (head.v) begin
            check("out_data", out_data, head.d);
            check("out_tag", out_tag, head.t);
`ifdef SHIFTER_FLAGS_EN
            check("out_zero", out_zero, head.d == '0);
            check("out_carry", out_carry, head.c);
`endif
            if (out_ready) begin
                cap_d.push_back(out_data);
                cap_t.push_back(out_tag);
            end
        end
        if (m_adv) begin
            nw.v = in_valid;
            nw.d = ref_res(in_op, int'(in_shamt), in_data);
            nw.t = in_tag;
            nw.c = ref_carry(in_op, int'(in_shamt), in_data);
            void'(pipe.pop_back());
            pipe.push_front(nw);
        end
    endtask

    task automatic step();
        @(negedge clock);
        observe();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input int sh,
                         input logic [WIDTH-1:0] d, input logic [TAGW-1:0] t);
        in_valid = v;
        in_op    = op;
        in_shamt = SHW'(sh);
        in_data  = d;
        in_tag   = t;
    endtask

`ifdef SHIFTER_FLAGS_EN
    task automatic flag_case(input string name, input logic [1:0] op, input int sh,
                             input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d,
                             input bit exp_z, input bit exp_c);
        drive(1, op, sh, d, TAGW'(5));
        step();
        drive(0, SLL, 0, '0, '0);
        repeat (SHW - 1) step();
        check({name, "_data"}, out_data, exp_d);
        check({name, "_zero"}, out_zero, exp_z);
        check({name, "_carry"}, out_carry, exp_c);
        step();
    endtask
`endif

    initial begin
        logic [WIDTH-1:0] b2b_exp[4];
        logic [TAGW-1:0]  b2b_tag[4];
        logic [63:0]      r64;
        logic [WIDTH-1:0] d;
        int               base;

        reset     = 1'b1;
        out_ready = 1'b1;
        drive(0, SLL, 0, '0, '0);
        model_reset();

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Pin the reference model itself.
        check("model_sll_max", ref_res(SLL, WIDTH - 1, WIDTH'(1)), top(8'h80));
        check("model_sra", ref_res(SRA, 4, top(8'h80)), top(8'hF8));
        check("model_srl", ref_res(SRL, 4, top(8'h80)), top(8'h08));
        check("model_ror", ref_res(ROR, 1, WIDTH'(1)), top(8'h80));
        check("model_shamt0", ref_res(SRA, 0, top(8'h80)), top(8'h80));
        check("model_carry_srl", ref_carry(SRL, 1, WIDTH'(3)), 1);
        check("model_carry_ror", ref_carry(ROR, 3, WIDTH'(1)), 0);

        // Latency of a single operation.
        drive(1, SLL, WIDTH - 1, WIDTH'(1), TAGW'(3));
        step();
        drive(0, SLL, 0, '0, '0);
        for (int i = 0; i < SHW - 2; i++) step();
        check("lat_early_valid", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, top(8'h80));
        check("lat_tag", out_tag, 3);
        repeat (SHW + 2) step();

        // Back-to-back at full rate.
        b2b_exp = '{top(8'hF8), top(8'h08), top(8'h80), '1};
        b2b_tag = '{TAGW'(1), TAGW'(2), TAGW'(3), TAGW'(4)};
        base = cap_d.size();
        drive(1, SRA, 4, top(8'h80), TAGW'(1)); step();
        drive(1, SRL, 4, top(8'h80), TAGW'(2)); step();
        drive(1, ROR, 1, WIDTH'(1), TAGW'(3));  step();
        drive(1, SLL, 0, '1, TAGW'(4));         step();
        drive(0, SLL, 0, '0, '0);
        repeat (SHW + 2) step();
        check("b2b_count", cap_d.size() - base, 4);
        if (cap_d.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("b2b_data%0d", i), cap_d[base+i], b2b_exp[i]);
                check($sformatf("b2b_tag%0d", i), cap_t[base+i], b2b_tag[i]);
            end
        end

        // Backpressure: fill the pipe, stall three cycles while offering ignored garbage.
        base = cap_d.size();
        for (int i = 0; i < SHW; i++) begin
            drive(1, 2'(i), i + 1, top(8'hA5), TAGW'(i));
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, ROR, WIDTH - 1, '1, '1);
            step();
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, top(8'h4A));
            check("bp_hold_tag", out_tag, 0);
        end
        drive(0, SLL, 0, '0, '0);
        out_ready = 1'b1;
        repeat (SHW + 2) step();
        check("bp_count", cap_d.size() - base, SHW);
        if (cap_d.size() - base == SHW) begin
            for (int i = 0; i < SHW; i++) check($sformatf("bp_tag%0d", i), cap_t[base+i], i);
        end

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, SRL, i, '1, TAGW'(i + 8));
            step();
        end
        drive(0, SLL, 0, '0, '0);
        base = cap_d.size();
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        step();
        reset = 1'b0;
        repeat (SHW + 2) step();
        check("arst_no_stale", cap_d.size() - base, 0);

`ifdef SHIFTER_FLAGS_EN
        flag_case("flag_srl", SRL, 1, WIDTH'(3), WIDTH'(1), 1'b0, 1'b1);
        flag_case("flag_sll", SLL, 1, top(8'h80), '0, 1'b1, 1'b1);
        flag_case("flag_ror", ROR, 3, top(8'hF8) | WIDTH'(5), ref_res(ROR, 3, top(8'hF8) | WIDTH'(5)),
                  1'b0, 1'b0);
`endif

        // Random regression with random backpressure.
        for (int n = 0; n < 10000; n++) begin
            r64 = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0:       d = '1;
                1:       d = top(8'h80);
                2:       d = WIDTH'(1);
                default: d = r64[WIDTH-1:0];
            endcase
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, WIDTH - 1), d, TAGW'($urandom_range(0, (1 << TAGW) - 1)));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drive(0, SLL, 0, '0, '0);
        out_ready = 1'b1;
        repeat (SHW + 2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
